// File: rtl/winner_screen_ctrl_pkg.sv
// Shared definitions for the end-of-round winner screen:
// result codes seen by the text drawer and the controller state encoding.
package winner_screen_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_SHOW    = 2'd2,
      ST_RESTART = 2'd3
   } state_e;

   localparam logic [1:0] WIN_NONE    = 2'b00;
   localparam logic [1:0] WIN_BOMBER1 = 2'b01;
   localparam logic [1:0] WIN_BOMBER2 = 2'b10;
   localparam logic [1:0] WIN_DRAW    = 2'b11;

   // The survivor wins: a dead bomber2 alone means bomber1 takes the round.
   function automatic logic [1:0] result_code(
      input logic d1,
      input logic d2
   );
      logic [1:0] code;
      code = WIN_NONE;
      if (d1 && d2) begin
         code = WIN_DRAW;
      end else if (d2) begin
         code = WIN_BOMBER1;
      end else if (d1) begin
         code = WIN_BOMBER2;
      end
      return code;
   endfunction

endpackage

// File: rtl/winner_screen_ctrl_rise_edge_det.sv
// Registered rising-edge detector; an input already high out of reset
// is not an edge until it has been seen low at least once.
module rise_edge_det
   import winner_screen_ctrl_pkg::*;
(
   input  logic i_pclk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_pulse
);

   logic prev_q;
   logic armed_q;
   logic pulse_q;

   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= i_sig;
         armed_q <= armed_q | ~i_sig;
         pulse_q <= i_sig & ~prev_q & armed_q;
      end
   end

   assign o_pulse = pulse_q;

endmodule

// File: rtl/winner_screen_ctrl.sv
// Freezes the game after a death, decides the winner over a few frames,
// blinks the result and issues a one-cycle restart on timeout or ack.
module winner_screen_ctrl
   import winner_screen_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_FRAMES = 2,
   parameter int unsigned SHOW_FRAMES   = 300,
   parameter int unsigned BLINK_FRAMES  = 30
) (
   input  logic       i_pclk,
   input  logic       i_rst,
   input  logic       i_vsync,
   input  logic       i_game_active,
   input  logic       i_bomber1_dead,
   input  logic       i_bomber2_dead,
   input  logic       i_ack,
   output logic [1:0] o_winner,
   output logic       o_text_visible,
   output logic       o_game_freeze,
   output logic       o_restart
);

   localparam logic [7:0]  SETTLE_N = 8'(SETTLE_FRAMES);
   localparam logic [15:0] SHOW_N   = 16'(SHOW_FRAMES);
   localparam logic [15:0] BLINK_N  = 16'(BLINK_FRAMES);

   logic tick;
   logic ack_edge;

   state_e      state_q, state_d;
   logic        d1_q, d1_d;
   logic        d2_q, d2_d;
   logic [7:0]  settle_q, settle_d;
   logic [15:0] show_q, show_d;
   logic [15:0] blink_q, blink_d;
   logic        blink_tog;

   logic [1:0]  winner_q, winner_d;
   logic        vis_q, vis_d;
   logic        freeze_q, freeze_d;
   logic        restart_q, restart_d;

   logic [7:0]  settle_inc;
   logic [15:0] show_inc;
   logic [15:0] blink_inc;

   assign settle_inc = settle_q + 8'd1;
   assign show_inc   = show_q + 16'd1;
   assign blink_inc  = blink_q + 16'd1;

   rise_edge_det u_vs_edge (
      .i_pclk  (i_pclk),
      .i_rst   (i_rst),
      .i_sig   (i_vsync),
      .o_pulse (tick)
   );

   rise_edge_det u_ack_edge (
      .i_pclk  (i_pclk),
      .i_rst   (i_rst),
      .i_sig   (i_ack),
      .o_pulse (ack_edge)
   );

   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         d1_q      <= 1'b0;
         d2_q      <= 1'b0;
         settle_q  <= 8'd0;
         show_q    <= 16'd0;
         blink_q   <= 16'd0;
         winner_q  <= WIN_NONE;
         vis_q     <= 1'b0;
         freeze_q  <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         settle_q  <= settle_d;
         show_q    <= show_d;
         blink_q   <= blink_d;
         winner_q  <= winner_d;
         vis_q     <= vis_d;
         freeze_q  <= freeze_d;
         restart_q <= restart_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      d1_d      = d1_q;
      d2_d      = d2_q;
      settle_d  = settle_q;
      show_d    = show_q;
      blink_d   = blink_q;
      blink_tog = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            d1_d     = 1'b0;
            d2_d     = 1'b0;
            settle_d = 8'd0;
            show_d   = 16'd0;
            blink_d  = 16'd0;
            if (i_game_active && (i_bomber1_dead || i_bomber2_dead)) begin
               state_d = ST_SETTLE;
               d1_d    = i_bomber1_dead;
               d2_d    = i_bomber2_dead;
            end
         end
         ST_SETTLE: begin
            d1_d = d1_q | i_bomber1_dead;
            d2_d = d2_q | i_bomber2_dead;
            if (tick) begin
               if (settle_inc == SETTLE_N) begin
                  state_d  = ST_SHOW;
                  settle_d = 8'd0;
                  show_d   = 16'd0;
                  blink_d  = 16'd0;
               end else begin
                  settle_d = settle_inc;
               end
            end
         end
         ST_SHOW: begin
            if (tick) begin
               show_d = show_inc;
               if (blink_inc == BLINK_N) begin
                  blink_d   = 16'd0;
                  blink_tog = 1'b1;
               end else begin
                  blink_d = blink_inc;
               end
            end
            // Timeout and ack in the same cycle collapse into one restart.
            if ((tick && show_inc == SHOW_N) || ack_edge) begin
               state_d = ST_RESTART;
            end
         end
         ST_RESTART: begin
            state_d = ST_IDLE;
            d1_d    = 1'b0;
            d2_d    = 1'b0;
            show_d  = 16'd0;
            blink_d = 16'd0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      winner_d  = winner_q;
      vis_d     = 1'b0;
      freeze_d  = (state_d != ST_IDLE);
      restart_d = (state_d == ST_RESTART);
      if (state_d == ST_IDLE) begin
         winner_d = WIN_NONE;
      end else if (state_q == ST_SETTLE && state_d == ST_SHOW) begin
         winner_d = result_code(d1_d, d2_d);
      end
      if (state_d == ST_SHOW) begin
         vis_d = (state_q == ST_SHOW) ? (vis_q ^ blink_tog) : 1'b1;
      end
   end

   assign o_winner       = winner_q;
   assign o_text_visible = vis_q;
   assign o_game_freeze  = freeze_q;
   assign o_restart      = restart_q;

endmodule

// File: tb/tb_winner_screen_ctrl.sv
// Scoreboard bench for winner_screen_ctrl: a frame-level reference model
// predicts every output change, a monitor pops and compares them.
module tb_winner_screen_ctrl;

   localparam int SET_F   = 2;
   localparam int SHOW_F  = 300;
   localparam int BLINK_F = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vs = 1'b0;
   logic       act = 1'b0;
   logic       b1 = 1'b0;
   logic       b2 = 1'b0;
   logic       ack = 1'b0;
   logic [1:0] win;
   logic       vis;
   logic       frz;
   logic       rs;

   winner_screen_ctrl #(
      .SETTLE_FRAMES (SET_F),
      .SHOW_FRAMES   (SHOW_F),
      .BLINK_FRAMES  (BLINK_F)
   ) dut (
      .i_pclk         (clk),
      .i_rst          (rst),
      .i_vsync        (vs),
      .i_game_active  (act),
      .i_bomber1_dead (b1),
      .i_bomber2_dead (b2),
      .i_ack          (ack),
      .o_winner       (win),
      .o_text_visible (vis),
      .o_game_freeze  (frz),
      .o_restart      (rs)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [4:0] out;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   // Monitor: every visible output change must match the next prediction.
   int         mon_edges = 0;
   logic [4:0] mon_prev = 5'b0;
   logic [4:0] mon_cur;
   ev_t        mon_ev;

   always @(posedge clk) mon_edges <= mon_edges + 1;

   always @(negedge clk) begin
      mon_cur = {win, vis, frz, rs};
      if (mon_cur !== mon_prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%b required=no change",
                     mon_edges, mon_cur);
         end else begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.cyc != mon_edges || mon_ev.out !== mon_cur) begin
               errors++;
               $display("FAIL out_event got cyc=%0d {win,vis,frz,rs}=%b required cyc=%0d %b",
                        mon_edges, mon_cur, mon_ev.cyc, mon_ev.out);
            end
         end
         mon_prev = mon_cur;
      end
   end

   // Reference model, evaluated once per rising edge on the sampled inputs.
   // ph: 0 idle, 1 settling, 2 showing, 3 restarting; tk counts frames in phase.
   int         k = 0;
   int         ph = 0;
   int         tk = 0;
   bit         md1, md2;
   logic [1:0] mwin = 2'b00;
   bit         vprev, vlow, aprev, alow, tickp, ackp;
   logic [4:0] mprev = 5'b0;
   int         vcnt = 0;
   bit         vs_ovr = 1'b0;

   function automatic void model_edge();
      bit         t, a, mv;
      logic [1:0] mw;
      logic [4:0] o;
      if (rst) begin
         ph = 0; tk = 0; md1 = 0; md2 = 0; mwin = 2'b00;
         vprev = 0; vlow = 0; aprev = 0; alow = 0; tickp = 0; ackp = 0;
      end else begin
         t = tickp;
         a = ackp;
         case (ph)
            0: if (act && (b1 || b2)) begin
               ph = 1; tk = 0; md1 = b1; md2 = b2;
            end
            1: begin
               md1 = md1 | b1;
               md2 = md2 | b2;
               if (t) begin
                  tk++;
                  if (tk == SET_F) begin
                     ph = 2; tk = 0;
                     if (md1 && md2) mwin = 2'b11;
                     else if (md2) mwin = 2'b01;
                     else mwin = 2'b10;
                  end
               end
            end
            2: begin
               if (t) tk++;
               if ((t && tk == SHOW_F) || a) ph = 3;
            end
            default: begin
               ph = 0; tk = 0; md1 = 0; md2 = 0; mwin = 2'b00;
            end
         endcase
         tickp = vs && !vprev && vlow;
         vlow  = vlow || !vs;
         vprev = vs;
         ackp  = ack && !aprev && alow;
         alow  = alow || !ack;
         aprev = ack;
      end
      mw = (ph >= 2) ? mwin : 2'b00;
      mv = (ph == 2) && (((tk / BLINK_F) % 2) == 0);
      o  = {mw, mv, (ph != 0), (ph == 3)};
      if (o != mprev) begin
         exp_q.push_back('{k, o});
         mprev = o;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      k++;
      model_edge();
      #1;
      vcnt++;
      if (!vs_ovr) vs = (((vcnt / 4) % 2) == 1);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_ph(input int p, input int lim, input string nm);
      int n;
      n = 0;
      while (ph != p && n < lim) begin
         step();
         n++;
      end
      if (ph != p) begin
         checks++;
         errors++;
         $display("FAIL %s timeout phase=%0d required=%0d", nm, ph, p);
      end
   endtask

   task automatic wait_show(input int n, input string nm);
      int c;
      c = 0;
      while (!(ph == 2 && tk == n) && c < 8 * (SHOW_F + 20)) begin
         step();
         c++;
      end
      if (!(ph == 2 && tk == n)) begin
         checks++;
         errors++;
         $display("FAIL %s timeout show_tick=%0d required=%0d", nm, tk, n);
      end
   endtask

   task automatic press_ack();
      ack = 1'b1;
      steps(2);
      ack = 1'b0;
      step();
   endtask

   task automatic death(input bit x1, input bit x2);
      b1 = x1;
      b2 = x2;
      step();
      b1 = 1'b0;
      b2 = 1'b0;
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if ({win, vis, frz, rs} !== 5'b0) begin
         errors++;
         $display("FAIL %s got=%b required=00000", nm, {win, vis, frz, rs});
      end
   endtask

   localparam int LONG = 8 * (SHOW_F + 20);

   initial begin
      int mode;
      int n;
      // Reset with vsync held high across release: no phantom first frame.
      vs_ovr = 1'b1;
      vs = 1'b1;
      steps(3);
      check_zero("reset_state");
      rst = 1'b0;
      act = 1'b1;
      b2 = 1'b1;
      step();
      b2 = 1'b0;
      steps(5);
      vs_ovr = 1'b0;
      wait_ph(2, LONG, "first_round_show");
      steps(3);
      press_ack();
      wait_ph(0, LONG, "first_round_idle");

      // bomber2 dies alone: bomber1 wins after two frames.
      steps(7);
      death(1'b0, 1'b1);
      wait_ph(2, LONG, "b1_wins_show");
      steps(10);
      press_ack();
      wait_ph(0, LONG, "b1_wins_idle");

      // Second death one frame later still inside the settle window: draw.
      steps(3);
      death(1'b1, 1'b0);
      n = 0;
      while (!(ph == 1 && tk == 1) && n < 100) begin
         step();
         n++;
      end
      death(1'b0, 1'b1);
      wait_ph(2, LONG, "draw_show");
      steps(20);
      press_ack();
      wait_ph(0, LONG, "draw_idle");

      // Full timeout with blinking, no ack.
      steps(5);
      death(1'b1, 1'b0);
      wait_ph(3, 8 * (SHOW_F + 40), "timeout_restart");
      wait_ph(0, 10, "timeout_idle");
      steps(4);

      // Ack held from settle into show must not skip; fresh press at tick 5 does.
      death(1'b0, 1'b1);
      step();
      ack = 1'b1;
      wait_ph(2, LONG, "ackheld_show");
      wait_show(3, "ackheld_t3");
      ack = 1'b0;
      wait_show(5, "ackheld_t5");
      ack = 1'b1;
      steps(4);
      ack = 1'b0;
      wait_ph(0, LONG, "ackheld_idle");

      // Reset in the middle of the show, then a normal round.
      death(1'b1, 1'b1);
      wait_show(50, "midreset_t50");
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_zero("midshow_reset");
      steps(9);
      death(1'b1, 1'b0);
      wait_ph(2, LONG, "post_reset_show");
      steps(12);
      press_ack();
      wait_ph(0, LONG, "post_reset_idle");

      // Deaths while no round is running are ignored.
      act = 1'b0;
      b1 = 1'b1;
      b2 = 1'b1;
      steps(24);
      checks++;
      if (frz !== 1'b0) begin
         errors++;
         $display("FAIL inactive_death freeze got=%b required=0", frz);
      end
      b1 = 1'b0;
      b2 = 1'b0;
      act = 1'b1;
      steps(3);

      // Randomised rounds.
      for (int r = 0; r < 24; r++) begin
         steps($urandom_range(1, 20));
         act = ($urandom_range(0, 4) != 0);
         {b1, b2} = 2'($urandom_range(1, 3));
         steps($urandom_range(1, 3));
         b1 = 1'b0;
         b2 = 1'b0;
         if (ph == 0) begin
            act = 1'b1;
            continue;
         end
         act = 1'b1;
         if ($urandom_range(0, 1) == 1) begin
            steps($urandom_range(1, 10));
            if ($urandom_range(0, 1) == 1) death(1'b1, 1'b0);
            else death(1'b0, 1'b1);
         end
         wait_ph(2, LONG, "rnd_show");
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            wait_ph(0, LONG, "rnd_timeout");
         end else if (mode == 1) begin
            wait_show($urandom_range(1, 60), "rnd_reset_tick");
            rst = 1'b1;
            steps($urandom_range(1, 2));
            rst = 1'b0;
         end else begin
            wait_show($urandom_range(0, 45), "rnd_ack_tick");
            ack = 1'b1;
            steps($urandom_range(1, 4));
            ack = 1'b0;
            wait_ph(0, LONG, "rnd_ack_idle");
         end
      end

      steps(20);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_events got=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
